// File: rtl/ble_rx_frame_parser.sv
// BLE control-path frame parser: delimits SOF/CMD/LEN/payload/CHK frames from
// the UART byte stream, checks length and XOR checksum, buffers the payload and
// holds each good frame for the consumer under a valid/ready handshake.
//
// Ports:
//   clk, rst_rx         clock, async active-high reset
//   in_byte, in_valid   received byte and its one-cycle strobe
//   out_valid/out_ready frame handshake; out_cmd/out_len describe the held frame
//   rd_index/rd_data    combinational payload read port (0 when index out of range)
//   err_pulse/err_code  one-cycle error strobe and sticky code of the last error
module ble_rx_frame_parser #(
    parameter logic [7:0]  SOF_BYTE       = 8'hAA,
    parameter int unsigned MAX_PAYLOAD    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_rx,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_cmd,
    output logic [7:0] out_len,
    input  logic [7:0] rd_index,
    output logic [7:0] rd_data,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    localparam int unsigned IDX_W      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0]  MAX_LEN    = 8'(MAX_PAYLOAD);
    localparam logic [23:0] TIMER_LAST = 24'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LENGTH  = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
    } state_t;

    state_t      state, state_d;
    logic [7:0]  cmd_d, len_d;
    logic [7:0]  acc, acc_d;
    logic [7:0]  cnt, cnt_d;
    logic [23:0] timer, timer_d;
    logic        out_valid_d, err_pulse_d;
    logic [1:0]  err_code_d;
    logic        wr_en;
    logic [7:0]  payload_q [MAX_PAYLOAD];

    // State and datapath registers; payload buffer written one byte per strobe
    always_ff @(posedge clk or posedge rst_rx) begin
        if (rst_rx) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_cmd   <= 8'h00;
            out_len   <= 8'h00;
            acc       <= 8'h00;
            cnt       <= 8'h00;
            timer     <= 24'h0;
            err_pulse <= 1'b0;
            err_code  <= ERR_OVERRUN;
            for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
                payload_q[i] <= 8'h00;
            end
        end else begin
            state     <= state_d;
            out_valid <= out_valid_d;
            out_cmd   <= cmd_d;
            out_len   <= len_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            timer     <= timer_d;
            err_pulse <= err_pulse_d;
            err_code  <= err_code_d;
            if (wr_en) begin
                payload_q[cnt[IDX_W-1:0]] <= in_byte;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        cmd_d       = out_cmd;
        len_d       = out_len;
        acc_d       = acc;
        cnt_d       = cnt;
        timer_d     = 24'h0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code;
        wr_en       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (in_valid && (in_byte == SOF_BYTE)) begin
                    state_d = S_CMD;
                    acc_d   = 8'h00;
                end
            end
            S_CMD, S_LEN, S_PAYLOAD, S_CHK: begin
                if (in_valid) begin
                    // A byte arriving on the timeout cycle wins over the timeout
                    unique case (state)
                        S_CMD: begin
                            cmd_d   = in_byte;
                            acc_d   = in_byte;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            if (in_byte > MAX_LEN) begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ERR_LENGTH;
                                state_d     = S_IDLE;
                            end else begin
                                len_d   = in_byte;
                                acc_d   = acc ^ in_byte;
                                cnt_d   = 8'h00;
                                state_d = (in_byte == 8'h00) ? S_CHK : S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            wr_en = 1'b1;
                            acc_d = acc ^ in_byte;
                            cnt_d = cnt + 8'd1;
                            if ((cnt + 8'd1) == out_len) begin
                                state_d = S_CHK;
                            end
                        end
                        default: begin
                            if (in_byte == acc) begin
                                state_d = S_HOLD;
                            end else begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ERR_CHKSUM;
                                state_d     = S_IDLE;
                            end
                        end
                    endcase
                end else if (timer == TIMER_LAST) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer + 24'd1;
                end
            end
            S_HOLD: begin
                // Bytes arriving while a frame is held are dropped
                if (in_valid) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d == S_HOLD);
    end

    // Combinational payload read port
    always_comb begin
        rd_data = 8'h00;
        if (rd_index < MAX_LEN) begin
            rd_data = payload_q[rd_index[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_ble_rx_frame_parser.sv
// Directed, table-driven bench for ble_rx_frame_parser: per-cycle vectors with
// hand-computed outputs plus hand sequences for payload reads, length boundary,
// timeout and mid-frame reset.
module tb_ble_rx_frame_parser;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst_rx;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_cmd;
    logic [7:0] out_len;
    logic [7:0] rd_index;
    logic [7:0] rd_data;
    logic       err_pulse;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       iv;
        logic [7:0] b;
        logic       rdy;
        logic       ev;
        logic       ep;
        logic [1:0] ec;
        logic [7:0] ecmd;
        logic [7:0] elen;
    } vec_t;

    vec_t tbl[$];

    ble_rx_frame_parser #(
        .SOF_BYTE(8'hAA),
        .MAX_PAYLOAD(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_rx(rst_rx),
        .in_byte(in_byte),
        .in_valid(in_valid),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cmd(out_cmd),
        .out_len(out_len),
        .rd_index(rd_index),
        .rd_data(rd_data),
        .err_pulse(err_pulse),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic iv, input logic [7:0] b, input logic rdy);
        in_valid  = iv;
        in_byte   = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic add(input logic iv, input logic [7:0] b, input logic rdy,
                       input logic ev, input logic ep, input logic [1:0] ec,
                       input logic [7:0] ecmd, input logic [7:0] elen);
        vec_t v;
        v.iv = iv; v.b = b; v.rdy = rdy; v.ev = ev; v.ep = ep;
        v.ec = ec; v.ecmd = ecmd; v.elen = elen;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].iv, tbl[i].b, tbl[i].rdy);
            check($sformatf("%s[%0d] {valid,pulse,code,cmd,len}", name, i),
                  32'({out_valid, err_pulse, err_code, out_cmd, out_len}),
                  32'({tbl[i].ev, tbl[i].ep, tbl[i].ec, tbl[i].ecmd, tbl[i].elen}));
        end
        tbl.delete();
    endtask

    task automatic check_rd(input string name, input logic [7:0] idx, input logic [7:0] exp);
        rd_index = idx;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int pulses;
        rst_rx    = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        rd_index  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 32'({out_valid, err_pulse, err_code, out_cmd, out_len}), 32'h0);
        check_rd("reset rd_data[0]", 8'd0, 8'h00);
        rst_rx = 1'b0;

        // Good frame after junk, held with out_ready low
        add(1, 8'h00, 0, 0, 0, 2'd0, 8'h00, 8'h00);
        add(1, 8'hFF, 0, 0, 0, 2'd0, 8'h00, 8'h00);
        add(1, 8'hAA, 0, 0, 0, 2'd0, 8'h00, 8'h00);
        add(1, 8'h10, 0, 0, 0, 2'd0, 8'h10, 8'h00);
        add(1, 8'h02, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h11, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h22, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h21, 0, 1, 0, 2'd0, 8'h10, 8'h02);
        add(0, 8'h00, 0, 1, 0, 2'd0, 8'h10, 8'h02);
        run_table("good");
        check_rd("good rd[0]", 8'd0, 8'h11);
        check_rd("good rd[1]", 8'd1, 8'h22);
        check_rd("rd index 16 out of range", 8'd16, 8'h00);
        check_rd("rd index 255 out of range", 8'd255, 8'h00);

        // Handshake, zero-length frame, then a one-byte frame
        add(0, 8'h00, 1, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'hAA, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h05, 0, 0, 0, 2'd0, 8'h05, 8'h02);
        add(1, 8'h00, 0, 0, 0, 2'd0, 8'h05, 8'h00);
        add(1, 8'h05, 0, 1, 0, 2'd0, 8'h05, 8'h00);
        add(0, 8'h00, 1, 0, 0, 2'd0, 8'h05, 8'h00);
        add(1, 8'hAA, 0, 0, 0, 2'd0, 8'h05, 8'h00);
        add(1, 8'h06, 0, 0, 0, 2'd0, 8'h06, 8'h00);
        add(1, 8'h01, 0, 0, 0, 2'd0, 8'h06, 8'h01);
        add(1, 8'h7E, 0, 0, 0, 2'd0, 8'h06, 8'h01);
        add(1, 8'h79, 0, 1, 0, 2'd0, 8'h06, 8'h01);
        run_table("zlen");
        check_rd("second rd[0]", 8'd0, 8'h7E);
        check_rd("stale rd[1]", 8'd1, 8'h22);

        // Bad checksum, recovery, then bad length
        add(0, 8'h00, 1, 0, 0, 2'd0, 8'h06, 8'h01);
        add(1, 8'hAA, 0, 0, 0, 2'd0, 8'h06, 8'h01);
        add(1, 8'h10, 0, 0, 0, 2'd0, 8'h10, 8'h01);
        add(1, 8'h02, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h11, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h22, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        add(1, 8'h20, 0, 0, 1, 2'd2, 8'h10, 8'h02);
        add(0, 8'h00, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'hAA, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'h10, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'h02, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'h11, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'h22, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'h21, 0, 1, 0, 2'd2, 8'h10, 8'h02);
        add(0, 8'h00, 1, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'hAA, 0, 0, 0, 2'd2, 8'h10, 8'h02);
        add(1, 8'h01, 0, 0, 0, 2'd2, 8'h01, 8'h02);
        add(1, 8'h11, 0, 0, 1, 2'd1, 8'h01, 8'h02);
        add(1, 8'h11, 0, 0, 0, 2'd1, 8'h01, 8'h02);
        run_table("errs");

        // Maximum length frame: LEN=16, payload 00..0F, CHK = 20^10 = 30
        step(1, 8'hAA, 0);
        step(1, 8'h20, 0);
        step(1, 8'h10, 0);
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(1, 8'h30, 0);
        check("max len {valid,cmd,len}", 32'({out_valid, out_cmd, out_len}), 32'({1'b1, 8'h20, 8'h10}));
        check_rd("max len rd[0]", 8'd0, 8'h00);
        check_rd("max len rd[15]", 8'd15, 8'h0F);

        // Overrun while held, including on the handshake cycle
        add(0, 8'h00, 1, 0, 0, 2'd1, 8'h20, 8'h10);
        add(1, 8'hAA, 0, 0, 0, 2'd1, 8'h20, 8'h10);
        add(1, 8'h10, 0, 0, 0, 2'd1, 8'h10, 8'h10);
        add(1, 8'h02, 0, 0, 0, 2'd1, 8'h10, 8'h02);
        add(1, 8'h11, 0, 0, 0, 2'd1, 8'h10, 8'h02);
        add(1, 8'h22, 0, 0, 0, 2'd1, 8'h10, 8'h02);
        add(1, 8'h21, 0, 1, 0, 2'd1, 8'h10, 8'h02);
        add(1, 8'h55, 0, 1, 1, 2'd0, 8'h10, 8'h02);
        add(0, 8'h00, 0, 1, 0, 2'd0, 8'h10, 8'h02);
        run_table("ovr");
        check_rd("overrun rd[0]", 8'd0, 8'h11);
        check_rd("overrun rd[1]", 8'd1, 8'h22);
        add(1, 8'h55, 1, 0, 1, 2'd0, 8'h10, 8'h02);
        add(0, 8'h00, 0, 0, 0, 2'd0, 8'h10, 8'h02);
        run_table("ovr_hs");

        // Timeout: silence for TO cycles after CMD
        step(1, 8'hAA, 0);
        step(1, 8'h10, 0);
        pulses = 0;
        for (int i = 0; i < int'(TO) - 1; i++) begin
            step(0, 8'h00, 0);
            if (err_pulse) pulses++;
        end
        check("no pulse before timeout", 32'(pulses), 32'd0);
        step(0, 8'h00, 0);
        check("timeout {pulse,code}", 32'({err_pulse, err_code}), 32'({1'b1, 2'd3}));
        step(0, 8'h00, 0);
        check("timeout pulse width", 32'(err_pulse), 32'd0);

        // Byte on exactly the timeout cycle keeps the frame alive
        step(1, 8'hAA, 0);
        step(1, 8'h10, 0);
        for (int i = 0; i < int'(TO) - 1; i++) step(0, 8'h00, 0);
        step(1, 8'h02, 0);
        check("byte on timeout edge no pulse", 32'(err_pulse), 32'd0);
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h21, 0);
        check("late byte frame {valid,cmd,len,code}", 32'({out_valid, out_cmd, out_len, err_code}),
              32'({1'b1, 8'h10, 8'h02, 2'd3}));
        step(0, 8'h00, 1);

        // Asynchronous reset mid-frame, then a clean frame
        step(1, 8'hAA, 0);
        step(1, 8'h10, 0);
        step(1, 8'h02, 0);
        step(1, 8'h11, 0);
        #2;
        rst_rx = 1'b1;
        #1;
        check("mid-frame reset outputs", 32'({out_valid, err_pulse, err_code, out_cmd, out_len}), 32'h0);
        check_rd("mid-frame reset rd[0]", 8'd0, 8'h00);
        @(posedge clk);
        #1;
        rst_rx = 1'b0;
        step(1, 8'hAA, 0);
        step(1, 8'h10, 0);
        step(1, 8'h02, 0);
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h21, 0);
        check("post-reset frame {valid,code,cmd,len}", 32'({out_valid, err_code, out_cmd, out_len}),
              32'({1'b1, 2'd0, 8'h10, 8'h02}));
        check_rd("post-reset rd[0]", 8'd0, 8'h11);
        check_rd("post-reset rd[1]", 8'd1, 8'h22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
